ccm_sequencer: RTL and testbench
================================

CCM_SEQUENCER -- requirements
Module: ccm_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 10: bit width of each pixel channel, in and out.
REQ-002 Parameter COEFF_WIDTH, default 8: bit width of each matrix coefficient.
REQ-003 Parameter COEFF_FRAC_WIDTH, default 5: fractional bits per coefficient; 1.0 is encoded as 32.
REQ-004 Parameter SIGNED_COEFF, default 1; parameter SIGNED_DATA, default 0; both are passed unchanged to the datapath.
REQ-005 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: a pixel is offered on in_pixel.
REQ-008 Port in_ready, output, 1: the block accepts the offered pixel this cycle.
REQ-009 Port in_pixel, input, 3*DATA_WIDTH: channel 0 in the MSBs, channel 2 in the LSBs.
REQ-010 Port out_valid, output, 1: out_pixel holds a complete result.
REQ-011 Port out_ready, input, 1: the downstream consumer accepts out_pixel.
REQ-012 Port out_pixel, output, 3*DATA_WIDTH: result channels, packed in the same order as in_pixel.
REQ-013 Port cfg_we, input, 1: write strobe for a shadow coefficient.
REQ-014 Port cfg_addr, input, 4: coefficient index, computed as row*3+col, valid range 0..8.
REQ-015 Port cfg_data, input, COEFF_WIDTH: value written to the shadow coefficient.
REQ-016 Port cfg_commit, input, 1: one-cycle pulse requesting a shadow-to-active copy.
REQ-017 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-018 One dot_product instance (LENGTH=3) SHALL be time-shared across the three output rows.
REQ-019 The FSM states SHALL be IDLE, ROW0, ROW1, ROW2 and HOLD.
REQ-020 in_ready SHALL equal (state==IDLE) OR (state==HOLD AND out_ready).
REQ-021 On in_valid AND in_ready, the pixel SHALL be registered and the next state SHALL be ROW0.
REQ-022 If IDLE has no handshake, the state SHALL stay IDLE.
REQ-023 If HOLD has out_ready but no new pixel, the next state SHALL be IDLE.
REQ-024 ROWk SHALL present the captured pixel and active row k to the datapath.
REQ-025 In ROWk the datapath datao SHALL be registered into out channel k.
REQ-026 ROWk SHALL advance to ROWk+1 unconditionally; ROW2 SHALL advance to HOLD.
REQ-027 out_valid SHALL be high only in HOLD.
REQ-028 out_pixel SHALL be stable while out_valid is high and out_ready is low.
REQ-029 Latency: a handshake at cycle N SHALL give out_valid at cycle N+4.
REQ-030 Sustained throughput with out_ready held high SHALL be one pixel per 4 cycles.
REQ-031 Result width, rounding and clipping SHALL be exactly those of dot_product datao; the block adds no arithmetic.
REQ-032 cfg_we with cfg_addr<=8 SHALL write shadow[cfg_addr].
REQ-033 cfg_we with cfg_addr>8 SHALL be ignored.
REQ-034 cfg_commit SHALL set commit_pending.
REQ-035 The active bank SHALL copy from the shadow bank only when commit_pending is set (or cfg_commit is high) in a cycle where state==IDLE or a handshake occurs.
REQ-036 commit_pending SHALL clear on that copy.
REQ-037 A copy in a handshake cycle SHALL apply to the pixel accepted in that cycle.
REQ-038 The active coefficients SHALL never change during ROW0..HOLD.
REQ-039 A cfg_we and a cfg_commit in the same cycle SHALL commit the newly written value.

Reset
REQ-040 Reset SHALL force state to IDLE.
REQ-041 Reset SHALL drive out_valid=0, busy=0, in_ready=1 from the next cycle.
REQ-042 Reset SHALL clear out_pixel to 0.
REQ-043 Reset SHALL clear commit_pending to 0.
REQ-044 Reset SHALL load both coefficient banks with identity: diagonal = 1<<COEFF_FRAC_WIDTH, all others 0.
REQ-045 Reset asserted mid-pixel SHALL discard that pixel with no out_valid produced for it.
REQ-046 Reset SHALL take priority over every simultaneous event.

Structure
REQ-047 The state encoding, coefficient count (9) and identity-matrix constant SHALL reside in the shared imager package.
REQ-048 The only sub-module SHALL be the existing dot_product; the row mux and coefficient banks SHALL stay in this module.

Verification
REQ-049 After reset, input (100,200,300) with out_ready=1 SHALL give out (100,200,300) at N+4, with busy high for N+1..N+4.
REQ-050 Writing the swap matrix (rows [0,0,32],[0,32,0],[32,0,0]) plus commit in IDLE, then input (100,200,300), SHALL give (300,200,100).
REQ-051 Row0=[16,16,16] committed, then input (100,200,300), SHALL give channel 0 = 300.
REQ-052 out_ready held low for 6 cycles in HOLD SHALL keep out_pixel and out_valid stable and in_ready low.
REQ-053 On out_ready rising, a waiting pixel SHALL be accepted in the same cycle.
REQ-054 A swap-matrix commit pulsed in ROW1 of pixel A SHALL leave A on identity and apply the swap to the next pixel B.
REQ-055 Reset asserted in ROW1 SHALL give no out_valid for that pixel and restore identity coefficients.
REQ-056 A write to cfg_addr=12 SHALL leave all nine coefficients unchanged.

Source files
------------

// File: rtl/ccm_sequencer_pkg.sv
// Shared constants for the colour-correction sequencer: FSM encoding,
// coefficient bank geometry and the identity-matrix layout.
package ccm_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW0,
    ST_ROW1,
    ST_ROW2,
    ST_HOLD
  } state_t;

  localparam int NUM_COEFFS     = 9;
  localparam int CFG_ADDR_WIDTH = 4;

  // Bit i set means coefficient index i (row*3+col) sits on the diagonal.
  localparam logic [NUM_COEFFS-1:0] IDENTITY_DIAG_MASK = 9'b1_0001_0001;

endpackage

// File: rtl/ccm_sequencer_if.sv
// Pixel stream, configuration and status bundle for ccm_sequencer.
// The master side drives pixels and configuration; the slave is the sequencer.
interface ccm_sequencer_if
  import ccm_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int COEFF_WIDTH = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic [3*DATA_WIDTH-1:0]   in_pixel;
  logic                      out_valid;
  logic                      out_ready;
  logic [3*DATA_WIDTH-1:0]   out_pixel;
  logic                      cfg_we;
  logic [CFG_ADDR_WIDTH-1:0] cfg_addr;
  logic [COEFF_WIDTH-1:0]    cfg_data;
  logic                      cfg_commit;
  logic                      busy;

  modport master (
    output in_valid, in_pixel, out_ready, cfg_we, cfg_addr, cfg_data, cfg_commit,
    input  in_ready, out_valid, out_pixel, busy
  );

  modport slave (
    input  in_valid, in_pixel, out_ready, cfg_we, cfg_addr, cfg_data, cfg_commit,
    output in_ready, out_valid, out_pixel, busy
  );

endinterface

// File: rtl/ccm_sequencer_dot_product.sv
// Combinational fixed-point dot product: sum(datai[i]*coeff[i]), rounded
// half-up at the coefficient binary point and clipped to the data range.
module dot_product #(
  parameter int LENGTH           = 3,
  parameter int DATA_WIDTH       = 10,
  parameter int COEFF_WIDTH      = 8,
  parameter int COEFF_FRAC_WIDTH = 5,
  parameter int SIGNED_COEFF     = 1,
  parameter int SIGNED_DATA      = 0
) (
  input  logic [LENGTH-1:0][DATA_WIDTH-1:0]  datai,
  input  logic [LENGTH-1:0][COEFF_WIDTH-1:0] coeff,
  output logic [DATA_WIDTH-1:0]              datao
);

  localparam int SW = DATA_WIDTH + COEFF_WIDTH + 3 + $clog2(LENGTH + 1);

  localparam logic signed [SW-1:0] HALF =
    SW'((64'(1) << COEFF_FRAC_WIDTH) >> 1);
  localparam logic signed [SW-1:0] MAX_VAL = (SIGNED_DATA != 0) ?
    SW'((64'(1) << (DATA_WIDTH - 1)) - 64'(1)) :
    SW'((64'(1) << DATA_WIDTH) - 64'(1));
  localparam logic signed [SW-1:0] MIN_VAL = (SIGNED_DATA != 0) ?
    -SW'(64'(1) << (DATA_WIDTH - 1)) : '0;

  logic signed [DATA_WIDTH:0]  d_ext;
  logic signed [COEFF_WIDTH:0] c_ext;
  logic signed [SW-1:0]        d_wide;
  logic signed [SW-1:0]        c_wide;
  logic signed [SW-1:0]        acc;
  logic signed [SW-1:0]        scaled;

  // NOTE: every variable gets a value before any branch or loop, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    d_ext  = '0;
    c_ext  = '0;
    d_wide = '0;
    c_wide = '0;
    acc    = '0;
    for (int i = 0; i < LENGTH; i++) begin
      d_ext  = (SIGNED_DATA != 0)  ? {datai[i][DATA_WIDTH-1], datai[i]}
                                   : {1'b0, datai[i]};
      c_ext  = (SIGNED_COEFF != 0) ? {coeff[i][COEFF_WIDTH-1], coeff[i]}
                                   : {1'b0, coeff[i]};
      d_wide = SW'(d_ext);
      c_wide = SW'(c_ext);
      acc    = acc + d_wide * c_wide;
    end
    scaled = (acc + HALF) >>> COEFF_FRAC_WIDTH;
    if (scaled > MAX_VAL)      datao = MAX_VAL[DATA_WIDTH-1:0];
    else if (scaled < MIN_VAL) datao = MIN_VAL[DATA_WIDTH-1:0];
    else                       datao = scaled[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/ccm_sequencer.sv
// 3x3 colour-correction sequencer: one shared dot product evaluates the three
// output rows in turn; coefficients are double-buffered (shadow -> active).
module ccm_sequencer
  import ccm_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH       = 10,
  parameter int COEFF_WIDTH      = 8,
  parameter int COEFF_FRAC_WIDTH = 5,
  parameter int SIGNED_COEFF     = 1,
  parameter int SIGNED_DATA      = 0
) (
  input logic            clk,
  input logic            reset,
  ccm_sequencer_if.slave bus
);

  typedef logic [COEFF_WIDTH-1:0] coeff_t;

  localparam coeff_t COEFF_ONE = COEFF_WIDTH'(1) << COEFF_FRAC_WIDTH;

  function automatic coeff_t identity_coeff(input int idx);
    return IDENTITY_DIAG_MASK[idx] ? COEFF_ONE : '0;
  endfunction

  state_t state, state_next;
  logic   ready, handshake, do_copy;
  logic   commit_pending;

  logic [2:0][DATA_WIDTH-1:0]  pixel_q;
  logic [2:0][DATA_WIDTH-1:0]  out_pixel_q;
  coeff_t                      shadow      [NUM_COEFFS];
  coeff_t                      shadow_next [NUM_COEFFS];
  coeff_t                      active      [NUM_COEFFS];
  logic [2:0][DATA_WIDTH-1:0]  dp_data;
  logic [2:0][COEFF_WIDTH-1:0] dp_coeff;
  logic [DATA_WIDTH-1:0]       dp_result;

  always_comb begin
    state_next = state;
    ready      = (state == ST_IDLE) || (state == ST_HOLD && bus.out_ready);
    handshake  = bus.in_valid && ready;
    unique case (state)
      ST_IDLE: if (handshake) state_next = ST_ROW0;
      ST_ROW0: state_next = ST_ROW1;
      ST_ROW1: state_next = ST_ROW2;
      ST_ROW2: state_next = ST_HOLD;
      ST_HOLD: begin
        if (handshake)         state_next = ST_ROW0;
        else if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_pixel = out_pixel_q;

  // Active bank only moves while no pixel is in flight, so a copy taken in a
  // handshake cycle is exactly what the newly accepted pixel will see.
  assign do_copy = (commit_pending || bus.cfg_commit) &&
                   (state == ST_IDLE || handshake);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: the captured pixel is not reset; it is only consumed after a
  // handshake has loaded it, so a reset term would add fan-out for nothing.
  always_ff @(posedge clk) begin
    if (handshake) pixel_q <= bus.in_pixel;
  end

  // Folding this cycle's write into the copy source makes a same-cycle
  // write+commit land the new value.
  always_comb begin
    for (int i = 0; i < NUM_COEFFS; i++) begin
      shadow_next[i] = (bus.cfg_we && bus.cfg_addr == CFG_ADDR_WIDTH'(i))
                       ? bus.cfg_data : shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_pending <= 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        shadow[i] <= identity_coeff(i);
        active[i] <= identity_coeff(i);
      end
    end else begin
      if (do_copy)             commit_pending <= 1'b0;
      else if (bus.cfg_commit) commit_pending <= 1'b1;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        shadow[i] <= shadow_next[i];
        if (do_copy) active[i] <= shadow_next[i];
      end
    end
  end

  // Row mux: channel 0 lives in the MSB lane of the packed pixel.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      dp_data[c] = pixel_q[2-c];
      unique case (state)
        ST_ROW1: dp_coeff[c] = active[3+c];
        ST_ROW2: dp_coeff[c] = active[6+c];
        default: dp_coeff[c] = active[c];
      endcase
    end
  end

  dot_product #(
    .LENGTH          (3),
    .DATA_WIDTH      (DATA_WIDTH),
    .COEFF_WIDTH     (COEFF_WIDTH),
    .COEFF_FRAC_WIDTH(COEFF_FRAC_WIDTH),
    .SIGNED_COEFF    (SIGNED_COEFF),
    .SIGNED_DATA     (SIGNED_DATA)
  ) u_dot (
    .datai(dp_data),
    .coeff(dp_coeff),
    .datao(dp_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pixel_q <= '0;
    end else begin
      unique case (state)
        ST_ROW0: out_pixel_q[2] <= dp_result;
        ST_ROW1: out_pixel_q[1] <= dp_result;
        ST_ROW2: out_pixel_q[0] <= dp_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccm_sequencer.sv
// Directed-vector bench for ccm_sequencer: latency, coefficient banking,
// backpressure and reset behaviour, all against hand-computed results.
module tb_ccm_sequencer;

  localparam int DW = 10;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ccm_sequencer_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus ();

  ccm_sequencer #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .COEFF_FRAC_WIDTH(5),
    .SIGNED_COEFF(1), .SIGNED_DATA(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*DW-1:0] px(input int a, input int b, input int c);
    logic [31:0] av, bv, cv;
    av = a; bv = b; cv = c;
    return {av[DW-1:0], bv[DW-1:0], cv[DW-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [CW-1:0] data, input logic commit);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 4'(addr);
    bus.cfg_data   = data;
    bus.cfg_commit = commit;
    step();
    bus.cfg_we     = 1'b0;
    bus.cfg_commit = 1'b0;
  endtask

  // Sends one pixel with out_ready high; commit_at (1..4) pulses cfg_commit
  // in that cycle after the handshake, 0 means no pulse.
  task automatic send_pixel(input string tag, input logic [3*DW-1:0] pix,
                            input logic [3*DW-1:0] exp, input int commit_at);
    int waited = 0;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_pixel = pix;
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (k < 4) begin
        check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      end else begin
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_pixel"}, 32'(bus.out_pixel), 32'(exp));
      end
      if (k == commit_at) bus.cfg_commit = 1'b1;
      step();
      bus.cfg_commit = 1'b0;
    end
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  logic [CW-1:0] swap_m [9];

  initial begin
    swap_m = '{8'd0, 8'd0, 8'd32, 8'd0, 8'd32, 8'd0, 8'd32, 8'd0, 8'd0};
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_pixel   = '0;
    bus.out_ready  = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_commit = 1'b0;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
    reset = 1'b0;
    step();

    // Identity after reset.
    send_pixel("ident", px(100, 200, 300), px(100, 200, 300), 0);

    // Swap matrix, last write and commit in the same cycle.
    for (int i = 0; i < 9; i++) cfg_write(i, swap_m[i], i == 8);
    send_pixel("swap", px(100, 200, 300), px(300, 200, 100), 0);

    // Row 0 averaging-style [16,16,16]; rows 1,2 still swap.
    cfg_write(0, 8'd16, 1'b0);
    cfg_write(1, 8'd16, 1'b0);
    cfg_write(2, 8'd16, 1'b1);
    send_pixel("row0_sum", px(100, 200, 300), px(300, 200, 100), 0);
    send_pixel("row0_small", px(10, 20, 30), px(30, 20, 10), 0);

    // Row 1 = [-1.0,0,0]: negative result clips to 0; row 0 saturates high.
    cfg_write(3, 8'hE0, 1'b0);
    cfg_write(4, 8'd0, 1'b1);
    send_pixel("clip", px(1023, 1023, 1023), px(1023, 0, 1023), 0);
    send_pixel("clip_small", px(10, 20, 30), px(30, 0, 10), 0);

    // Reset in ROW1 discards the pixel and restores identity.
    begin
      bit seen_valid = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_pixel = px(100, 200, 300);
      step();
      bus.in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_busy",      32'(bus.busy),      32'd0);
      check("midrst_out_pixel", 32'(bus.out_pixel), 32'd0);
      for (int i = 0; i < 6; i++) begin
        if (bus.out_valid) seen_valid = 1'b1;
        step();
      end
      check("midrst_no_valid", 32'(seen_valid), 32'd0);
    end
    send_pixel("midrst_ident", px(100, 200, 300), px(100, 200, 300), 0);

    // Backpressure in HOLD with a second pixel waiting.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pixel  = px(1, 2, 3);
    step();
    bus.in_pixel  = px(4, 5, 6);
    for (int i = 0; i < 3; i++) step();
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_pixel", 32'(bus.out_pixel), 32'(px(1, 2, 3)));
    for (int i = 0; i < 6; i++) begin
      step();
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_pixel", 32'(bus.out_pixel), 32'(px(1, 2, 3)));
      check("bp_hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_b_row0_valid", 32'(bus.out_valid), 32'd0);
    check("bp_b_row0_busy",  32'(bus.busy),      32'd1);
    for (int i = 0; i < 3; i++) step();
    check("bp_b_valid", 32'(bus.out_valid), 32'd1);
    check("bp_b_pixel", 32'(bus.out_pixel), 32'(px(4, 5, 6)));
    step();
    check("bp_b_idle", 32'(bus.busy), 32'd0);

    // Commit pulsed in ROW1 of A: A stays identity, B sees the swap.
    for (int i = 0; i < 9; i++) cfg_write(i, swap_m[i], 1'b0);
    send_pixel("late_commit_a", px(100, 200, 300), px(100, 200, 300), 2);
    send_pixel("late_commit_b", px(100, 200, 300), px(300, 200, 100), 0);

    // Out-of-range address must not disturb any coefficient.
    cfg_write(12, 8'h55, 1'b1);
    send_pixel("bad_addr", px(100, 200, 300), px(300, 200, 100), 0);
    send_pixel("bad_addr2", px(7, 400, 1000), px(1000, 400, 7), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
